// File: rtl/ddr_fifo_burst_scheduler_if.sv
// Handshake bundle between the DDR FIFO burst scheduler and its
// surrounding staging FIFOs and AXI burst engines.
interface ddr_fifo_burst_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned LVL_WIDTH  = 11
);
  logic                  enable;
  logic                  flush;
  logic [CNT_WIDTH-1:0]  in_fifo_cnt;
  logic [CNT_WIDTH-1:0]  out_fifo_space;
  logic                  wr_burst_done;
  logic                  rd_burst_done;
  logic                  wr_start;
  logic                  rd_start;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LVL_WIDTH-1:0]  level;
  logic                  ddr_full;
  logic                  ddr_empty;
  logic                  busy;
  logic                  proto_err;

  // Scheduler side
  modport slave (
    input  enable, flush, in_fifo_cnt, out_fifo_space, wr_burst_done, rd_burst_done,
    output wr_start, rd_start, wr_addr, rd_addr, level, ddr_full, ddr_empty, busy, proto_err
  );

  // Controller / environment side
  modport master (
    output enable, flush, in_fifo_cnt, out_fifo_space, wr_burst_done, rd_burst_done,
    input  wr_start, rd_start, wr_addr, rd_addr, level, ddr_full, ddr_empty, busy, proto_err
  );
endinterface

// File: rtl/ddr_fifo_burst_scheduler.sv
// Arbitrates single AXI write/read bursts against a DDR ring buffer and
// tracks the ring pointers and committed fill level in bursts.
module ddr_fifo_burst_scheduler #(
  parameter int unsigned ADDR_WIDTH  = 30,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned RING_BURSTS = 1024,
  parameter int unsigned CNT_WIDTH   = 12
) (
  input logic M_AXI_ACLK,
  input logic M_AXI_ARESETN,
  ddr_fifo_burst_scheduler_if.slave sif
);

  localparam int unsigned BB    = BURST_LEN * DATA_WIDTH / 8;
  localparam int unsigned LVL_W = $clog2(RING_BURSTS + 1);
  localparam int unsigned PTR_W = (RING_BURSTS > 1) ? $clog2(RING_BURSTS) : 1;

  typedef enum logic [1:0] {IDLE, WR_RUN, RD_RUN} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                  wr_start_q, wr_start_d, rd_start_q, rd_start_d;
  logic                  full_q, full_d, empty_q, empty_d, busy_q, busy_d;
  logic                  err_q, err_d, flush_pend_q, flush_pend_d;
  logic                  last_rd_q, last_rd_d;
  logic                  wr_ok, rd_ok, flush_now;

  function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [PTR_W-1:0] p);
    return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(p) * ADDR_WIDTH'(BB);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RING_BURSTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state, pointer and output computation
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_start_d   = 1'b0;
    rd_start_d   = 1'b0;
    err_d        = err_q;
    flush_pend_d = flush_pend_q;
    last_rd_d    = last_rd_q;

    wr_ok     = sif.enable && (sif.in_fifo_cnt >= CNT_WIDTH'(BURST_LEN)) &&
                (level_q < LVL_W'(RING_BURSTS));
    rd_ok     = sif.enable && (level_q != '0) &&
                (sif.out_fifo_space >= CNT_WIDTH'(BURST_LEN));
    flush_now = sif.flush || flush_pend_q;

    case (state_q)
      IDLE: begin
        if (flush_now) begin
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          level_d      = '0;
          wr_addr_d    = ADDR_WIDTH'(BASE_ADDR);
          rd_addr_d    = ADDR_WIDTH'(BASE_ADDR);
          err_d        = 1'b0;
          flush_pend_d = 1'b0;
        end else if (wr_ok && (!rd_ok || last_rd_q)) begin
          state_d    = WR_RUN;
          wr_start_d = 1'b1;
          wr_addr_d  = burst_addr(wr_ptr_q);
          last_rd_d  = 1'b0;
        end else if (rd_ok) begin
          state_d    = RD_RUN;
          rd_start_d = 1'b1;
          rd_addr_d  = burst_addr(rd_ptr_q);
          last_rd_d  = 1'b1;
        end
        if (sif.wr_burst_done || sif.rd_burst_done) err_d = 1'b1;
      end
      WR_RUN: begin
        if (sif.wr_burst_done) begin
          state_d  = IDLE;
          level_d  = level_q + LVL_W'(1);
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (sif.rd_burst_done) err_d = 1'b1;
        if (sif.flush) flush_pend_d = 1'b1;
      end
      RD_RUN: begin
        if (sif.rd_burst_done) begin
          state_d  = IDLE;
          level_d  = level_q - LVL_W'(1);
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (sif.wr_burst_done) err_d = 1'b1;
        if (sif.flush) flush_pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    full_d  = (level_d == LVL_W'(RING_BURSTS));
    empty_d = (level_d == '0);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      wr_addr_q    <= ADDR_WIDTH'(BASE_ADDR);
      rd_addr_q    <= ADDR_WIDTH'(BASE_ADDR);
      wr_start_q   <= 1'b0;
      rd_start_q   <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      last_rd_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_start_q   <= wr_start_d;
      rd_start_q   <= rd_start_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
      last_rd_q    <= last_rd_d;
    end
  end

  assign sif.wr_start  = wr_start_q;
  assign sif.rd_start  = rd_start_q;
  assign sif.wr_addr   = wr_addr_q;
  assign sif.rd_addr   = rd_addr_q;
  assign sif.level     = level_q;
  assign sif.ddr_full  = full_q;
  assign sif.ddr_empty = empty_q;
  assign sif.busy      = busy_q;
  assign sif.proto_err = err_q;

endmodule

// File: tb/tb_ddr_fifo_burst_scheduler.sv
// Directed bench for the DDR FIFO burst scheduler on a 4-burst ring of
// 128-byte bursts based at address 0.
module tb_ddr_fifo_burst_scheduler;

  localparam int unsigned ADDR_WIDTH  = 30;
  localparam int unsigned CNT_WIDTH   = 12;
  localparam int unsigned RING_BURSTS = 4;
  localparam int unsigned LVL_WIDTH   = $clog2(RING_BURSTS + 1);

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ddr_fifo_burst_scheduler_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH), .LVL_WIDTH(LVL_WIDTH)
  ) bus ();

  ddr_fifo_burst_scheduler #(
    .ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(16), .DATA_WIDTH(64), .BASE_ADDR(0),
    .RING_BURSTS(RING_BURSTS), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .sif(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a start pulse, then check side, address, latency and pulse width
  task automatic start_burst(input string tag, input bit exp_wr, input int exp_addr,
                             input int exp_lat);
    bit seen = 1'b0;
    int lat  = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      lat++;
      seen = bus.wr_start || bus.rd_start;
    end
    chk({tag, "_granted"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_side_wr"}, 32'(bus.wr_start), 32'(exp_wr));
      chk({tag, "_addr"}, exp_wr ? 32'(bus.wr_addr) : 32'(bus.rd_addr), 32'(exp_addr));
      if (exp_lat > 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      tick();
      chk({tag, "_pulse1"}, 32'(bus.wr_start || bus.rd_start), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
  endtask

  // Pulse the matching done and check the one-cycle idle gap
  task automatic end_burst(input string tag, input bit is_wr, input int exp_level);
    if (is_wr) bus.wr_burst_done = 1'b1;
    else       bus.rd_burst_done = 1'b1;
    tick();
    bus.wr_burst_done = 1'b0;
    bus.rd_burst_done = 1'b0;
    chk({tag, "_gap"}, 32'(bus.wr_start || bus.rd_start || bus.busy), 32'd0);
    chk({tag, "_level"}, 32'(bus.level), 32'(exp_level));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.flush = 1'b0;
    bus.in_fifo_cnt = '0;
    bus.out_fifo_space = '0;
    bus.wr_burst_done = 1'b0;
    bus.rd_burst_done = 1'b0;
    repeat (3) tick();

    chk("rst_starts", 32'(bus.wr_start || bus.rd_start), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_empty", 32'(bus.ddr_empty), 32'd1);
    chk("rst_full", 32'(bus.ddr_full), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.proto_err), 32'd0);

    rst_n = 1'b1;
    tick();

    // Basic write and fill to full
    bus.enable = 1'b1;
    bus.in_fifo_cnt = 12'd16;
    start_burst("w0", 1'b1, 0, 1);
    end_burst("w0", 1'b1, 1);
    chk("w0_empty", 32'(bus.ddr_empty), 32'd0);
    start_burst("w1", 1'b1, 128, 1);
    end_burst("w1", 1'b1, 2);
    start_burst("w2", 1'b1, 256, 1);
    end_burst("w2", 1'b1, 3);
    start_burst("w3", 1'b1, 384, 1);
    end_burst("w3", 1'b1, 4);
    chk("fill_full", 32'(bus.ddr_full), 32'd1);
    begin
      int starts = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (bus.wr_start || bus.rd_start) starts++;
      end
      chk("full_no_start", 32'(starts), 32'd0);
    end

    // Drain one, then the tie goes to write at the wrapped address
    bus.out_fifo_space = 12'd16;
    start_burst("r0", 1'b0, 0, 1);
    end_burst("r0", 1'b0, 3);
    start_burst("wwrap", 1'b1, 0, 1);
    bus.enable = 1'b0;
    end_burst("wwrap", 1'b1, 4);
    begin
      int starts = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (bus.wr_start || bus.rd_start) starts++;
      end
      chk("dis_no_start", 32'(starts), 32'd0);
    end

    // Flush while idle
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("iflush_level", 32'(bus.level), 32'd0);
    chk("iflush_empty", 32'(bus.ddr_empty), 32'd1);

    // Round-robin with both sides fed
    bus.enable = 1'b1;
    start_burst("rr_w0", 1'b1, 0, 1);
    end_burst("rr_w0", 1'b1, 1);
    start_burst("rr_r0", 1'b0, 0, 1);
    end_burst("rr_r0", 1'b0, 0);
    start_burst("rr_w1", 1'b1, 128, 1);
    end_burst("rr_w1", 1'b1, 1);
    start_burst("rr_r1", 1'b0, 128, 1);
    end_burst("rr_r1", 1'b0, 0);

    // Stray read-done during a write
    start_burst("pe_w", 1'b1, 256, 1);
    bus.rd_burst_done = 1'b1;
    tick();
    bus.rd_burst_done = 1'b0;
    chk("pe_err", 32'(bus.proto_err), 32'd1);
    chk("pe_level", 32'(bus.level), 32'd0);
    chk("pe_busy", 32'(bus.busy), 32'd1);
    end_burst("pe_w", 1'b1, 1);
    chk("pe_err_sticky", 32'(bus.proto_err), 32'd1);
    start_burst("pe_r", 1'b0, 256, 1);

    // Flush during the read is deferred to the first idle cycle
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("mflush_busy", 32'(bus.busy), 32'd1);
    chk("mflush_level", 32'(bus.level), 32'd1);
    chk("mflush_err", 32'(bus.proto_err), 32'd1);
    end_burst("mflush_r", 1'b0, 0);
    tick();
    chk("mflush_nogrant", 32'(bus.wr_start || bus.rd_start), 32'd0);
    chk("mflush_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("mflush_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("mflush_err_clr", 32'(bus.proto_err), 32'd0);
    start_burst("mflush_w", 1'b1, 0, 1);
    end_burst("mflush_w", 1'b1, 1);
    start_burst("pre_r", 1'b0, 0, 1);
    end_burst("pre_r", 1'b0, 0);

    // Asynchronous reset in the middle of a write
    start_burst("rb_w", 1'b1, 128, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("arst_level", 32'(bus.level), 32'd0);
    chk("arst_empty", 32'(bus.ddr_empty), 32'd1);
    tick();
    rst_n = 1'b1;
    start_burst("post_rst_w", 1'b1, 0, 1);
    end_burst("post_rst_w", 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_fifo_burst_scheduler.md
Name: ddr_fifo_burst_scheduler

Overview:
Sequencing controller for the DDR-backed FIFO. It decides when the AXI write-burst engine and the AXI read-burst engine each run one burst, and only one runs at a time. It keeps the DDR ring-buffer write and read pointers and the fill level in bursts. It hands each engine a start pulse plus a burst base address, and sits between the input/output staging FIFOs and the AXI channel blocks.

Parameters:
ADDR_WIDTH, 30, AXI byte-address width
BURST_LEN, 16, beats per AXI burst
DATA_WIDTH, 64, AXI data width in bits; burst size in bytes BB = BURST_LEN*DATA_WIDTH/8
BASE_ADDR, 0, byte address of ring start; must be BB-aligned
RING_BURSTS, 1024, ring capacity in bursts; need not be a power of 2
CNT_WIDTH, 12, width of staging-FIFO count/space inputs

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  asynchronous active-low reset
enable  in  1  scheduling enable
flush  in  1  pulse; clear pointers and level
in_fifo_cnt  in  CNT_WIDTH  words waiting in the input staging FIFO
out_fifo_space  in  CNT_WIDTH  free words in the output staging FIFO
wr_burst_done  in  1  pulse; write burst complete (B handshake)
rd_burst_done  in  1  pulse; read burst complete (RLAST & RVALID)
wr_start  out  1  one-cycle pulse; start one write burst
rd_start  out  1  one-cycle pulse; start one read burst
wr_addr  out  ADDR_WIDTH  write burst base address
rd_addr  out  ADDR_WIDTH  read burst base address
level  out  clog2(RING_BURSTS+1)  committed bursts held in DDR
ddr_full  out  1  level == RING_BURSTS
ddr_empty  out  1  level == 0
busy  out  1  state != IDLE
proto_err  out  1  sticky; unexpected done pulse

Behaviour:
- Reset (async assert, sync release): state IDLE; wr_start=rd_start=0; wr_ptr=rd_ptr=0; level=0; wr_addr=rd_addr=BASE_ADDR; ddr_empty=1; ddr_full=0; busy=0; proto_err=0; last_grant=RD, so the first tie goes to write.
- All outputs are registered.
- Eligibility, evaluated combinationally in IDLE only:
  - wr_ok = enable & in_fifo_cnt>=BURST_LEN & level<RING_BURSTS
  - rd_ok = enable & level>0 & out_fifo_space>=BURST_LEN
- FSM states: IDLE, WR_RUN, RD_RUN.
- IDLE transitions:
  - Only wr_ok: go to WR_RUN; wr_start=1 for exactly the next cycle; wr_addr = BASE_ADDR + wr_ptr*BB on that same edge.
  - Only rd_ok: same as above, using RD_RUN, rd_start, rd_addr and rd_ptr.
  - Both: round-robin; grant the side opposite last_grant; last_grant updates on every grant.
  - Neither: stay in IDLE.
- WR_RUN exit on wr_burst_done:
  - Next state IDLE; level+1; wr_ptr+1, wrapping RING_BURSTS-1 -> 0.
  - A new grant can happen no earlier than the cycle after returning to IDLE, so there is a one-cycle gap between bursts.
- RD_RUN exit on rd_burst_done: next state IDLE; level-1; rd_ptr+1 with the same wrap.
- Done-pulse checking:
  - wr_burst_done outside WR_RUN, or rd_burst_done outside RD_RUN: set proto_err; state, pointers and level are unchanged.
  - Both done pulses in the same cycle: the one matching the current state is honoured; the other sets proto_err.
- Address stability: wr_addr and rd_addr hold from the start pulse until the next grant of the same side.
- Address arithmetic: ptr*BB is computed in ADDR_WIDTH bits and never exceeds BASE_ADDR + (RING_BURSTS-1)*BB.
- enable deasserted mid-burst: the current burst runs to its done pulse, then the FSM stays in IDLE.
- flush:
  - Honoured only in IDLE: wr_ptr=rd_ptr=0, level=0, addresses=BASE_ADDR, proto_err=0.
  - flush outside IDLE is latched and applied on the first IDLE cycle.
  - No grant is issued in the cycle a flush is applied.
- Level bounds: level never exceeds RING_BURSTS and never underflows, since eligibility already blocks both cases.
- Reset mid-burst: immediate return to the reset values; no done pulse is expected afterwards.

Test Plan:
- Basic write: RING_BURSTS=4, BB=128, in_fifo_cnt=16, out_fifo_space=0 -> wr_start one cycle after the eligible cycle, wr_addr=0; after wr_burst_done, level=1 and ddr_empty=0; the next wr_start shows wr_addr=128.
- Fill and wrap: four write bursts -> ddr_full=1 and no further wr_start despite in_fifo_cnt=16. Raise out_fifo_space=16 -> one read at rd_addr=0 and level=3. The next write is at wr_addr=0 (wrapped).
- Round-robin: both sides eligible continuously -> grants alternate W,R,W,R starting with W; each burst is followed by one IDLE cycle.
- Protocol error: inject rd_burst_done during WR_RUN -> proto_err=1 and latched; level and rd_ptr unchanged; the write still completes normally on wr_burst_done.
- Flush mid-burst: assert flush during RD_RUN -> flush takes effect only after rd_burst_done; then level=0, both addresses=BASE_ADDR, proto_err=0, and no grant in the flush cycle.
- Reset mid-burst: deassert M_AXI_ARESETN during WR_RUN -> all outputs return to reset values asynchronously; after release, the first eligible grant is a write to BASE_ADDR.
